// File: rtl/qdec_pkg.sv
// Shared phase-state encodings, direction values and transition classifier for the quadrature decoder.
// Latency: n/a (constants and pure functions). Backpressure: none.
package qdec_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int FILTER_LEN_MAX = 16;
    localparam int FILT_CNT_W     = $clog2(FILTER_LEN_MAX);
    localparam int SETTLE_W       = $clog2(FILTER_LEN_MAX + 4);

    typedef enum logic {ST_SETTLE, ST_RUN} state_t;
    typedef enum logic [1:0] {MOVE_NONE, MOVE_UP, MOVE_DOWN, MOVE_ERR} move_t;

    // Forward (A leads) Gray successor of a phase state.
    function automatic logic [1:0] next_up(input logic [1:0] s);
        case (s)
            S00:     next_up = S10;
            S10:     next_up = S11;
            S11:     next_up = S01;
            default: next_up = S00;
        endcase
    endfunction

    function automatic move_t classify(input logic [1:0] prev, input logic [1:0] cur);
        if (cur == prev)
            return MOVE_NONE;
        else if (cur == ~prev)
            return MOVE_ERR;
        else if (cur == next_up(prev))
            return MOVE_UP;
        else
            return MOVE_DOWN;
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// One encoder channel: 2-flop synchronizer, plus a FILTER_LEN-cycle glitch filter when QDEC_FILTER_EN is defined.
// Latency: 2 cycles (sync only) or 2+FILTER_LEN cycles (filtered). Backpressure: none.
module qdec_filter
    import qdec_pkg::*;
`ifdef QDEC_FILTER_EN
#(
    parameter int FILTER_LEN = 4
)
`endif
(
    input  logic clock,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    logic s1, s2;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef QDEC_FILTER_EN
    logic                  held;
    logic [FILT_CNT_W-1:0] cnt;

    // A new level is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            held <= 1'b0;
            cnt  <= '0;
        end else if (s2 == held) begin
            cnt <= '0;
        end else if (cnt == FILT_CNT_W'(FILTER_LEN - 1)) begin
            held <= s2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign filt = held;
`else
    assign filt = s2;
`endif

endmodule

// File: rtl/quad_decoder.sv
// 4x quadrature decoder with WIDTH-bit position, direction, step pulse and sticky error; QDEC_FILTER_EN adds glitch filters.
// Latency: count/step update 3 cycles after the input edge (3+FILTER_LEN filtered). Backpressure: none.
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int WIDTH      = 6,
    parameter int FILTER_LEN = 4
)(
    input  logic             clock,
    input  logic             rst_n,
    input  logic             phase_a,
    input  logic             phase_b,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    if (FILTER_LEN < 2 || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_filter_len
        $error("quad_decoder: FILTER_LEN must be within 2..16");
    end

    // The init phase lasts until the reset zeros have drained from the sync/filter
    // pipeline, so an encoder resting at 11/01/10 is captured as prev without an err.
`ifdef QDEC_FILTER_EN
    localparam int SETTLE = 3 + FILTER_LEN;
`else
    localparam int SETTLE = 3;
`endif

    logic a, b;

    qdec_filter
`ifdef QDEC_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
    u_filt_a (
        .clock (clock),
        .rst_n (rst_n),
        .raw   (phase_a),
        .filt  (a)
    );

    qdec_filter
`ifdef QDEC_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
    u_filt_b (
        .clock (clock),
        .rst_n (rst_n),
        .raw   (phase_b),
        .filt  (b)
    );

    state_t              state;
    logic [SETTLE_W-1:0] settle;
    logic [1:0]          prev;
    move_t               move;

    assign move = classify(prev, {a, b});

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_SETTLE;
            settle <= SETTLE_W'(SETTLE - 1);
            prev   <= S00;
            count  <= '0;
            dir    <= DIR_DOWN;
            step   <= 1'b0;
            err    <= 1'b0;
        end else begin
            step <= 1'b0;
            prev <= {a, b};
            if (clear) begin
                count <= '0;
                err   <= 1'b0;
            end
            case (state)
                ST_SETTLE: begin
                    if (settle == '0)
                        state <= ST_RUN;
                    else
                        settle <= settle - 1'b1;
                end
                default: begin
                    // clear wins over a coincident step; prev still advances above.
                    if (!clear) begin
                        case (move)
                            MOVE_UP: begin
                                count <= count + 1'b1;
                                dir   <= DIR_UP;
                                step  <= 1'b1;
                            end
                            MOVE_DOWN: begin
                                count <= count - 1'b1;
                                dir   <= DIR_DOWN;
                                step  <= 1'b1;
                            end
                            MOVE_ERR: err <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
